// File: rtl/cory_spram_ctrl_if.sv
// Request/response bundle for cory_spram_ctrl: client-facing valid/ready channels.
// master = client engine, slave = controller.
interface cory_spram_ctrl_if #(
  parameter int A = 8,
  parameter int D = 8
) ();
  logic         i_v;
  logic         i_r;
  logic         i_we;
  logic [A-1:0] i_a;
  logic [D-1:0] i_d;
  logic         o_v;
  logic         o_r;
  logic [D-1:0] o_d;
  logic         o_err;

  modport master (
    output i_v, i_we, i_a, i_d, o_r,
    input  i_r, o_v, o_d, o_err
  );

  modport slave (
    input  i_v, i_we, i_a, i_d, o_r,
    output i_r, o_v, o_d, o_err
  );
endinterface

// File: rtl/cory_spram_ctrl.sv
// Initiator-side controller for a single-port SRAM with registered read data and in-order responses.
// Optional macro CORY_SPRAM_CTRL_RANGE_CHK_EN: out-of-range requests become bubbles / error responses.
module cory_spram_ctrl #(
  parameter int A     = 8,
  parameter int D     = 8,
  parameter int SIZE  = 2**A,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  cory_spram_ctrl_if.slave bus,
  output logic         mem_csn,
  output logic         mem_wen,
  output logic         mem_oen,
  output logic [A-1:0] mem_addr,
  output logic [D-1:0] mem_wdata,
  input  logic [D-1:0] mem_rdata,
  output logic         busy
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  generate
    if (DEPTH < 1 || DEPTH > 16 || SIZE < 1 || SIZE > 2**A) begin : g_bad_cfg
      $error("cory_spram_ctrl: illegal DEPTH or SIZE");
    end
  endgenerate

  // Both channels: a beat transfers at a posedge where valid && ready; ready never
  // looks at valid or payload, and payload is sampled only at that edge.
  logic          accept;
  logic          in_range;
  logic          s1_rd, s1_hit;
  logic          s2_rd, s2_hit;
  logic [1:0]    inflight;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   used;
  logic [PW-1:0] wptr, rptr;
  logic [D-1:0]  data_q [DEPTH];
  logic          push, pop;
  logic [D-1:0]  push_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Every accepted read reserves a FIFO slot until popped, so the FIFO can never overflow.
  assign inflight = {1'b0, s1_rd} + {1'b0, s2_rd};
  assign used     = {1'b0, fifo_cnt} + (CW+1)'(inflight);
  assign bus.i_r  = !reset && (used < (CW+1)'(DEPTH));
  assign accept   = bus.i_v && bus.i_r;

`ifdef CORY_SPRAM_CTRL_RANGE_CHK_EN
  localparam logic [A:0] SIZE_L = (A+1)'(SIZE);
  logic       err_q [DEPTH];
  logic [7:0] err_cnt;

  assign in_range = ({1'b0, bus.i_a} < SIZE_L);

  always_ff @(posedge clk) begin
    if (push) err_q[wptr] <= !s2_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (accept && !in_range && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign bus.o_err = bus.o_v && err_q[rptr];
`else
  assign in_range  = 1'b1;
  assign bus.o_err = 1'b0;
`endif

  // s*_rd tracks every read slot (credit, ordering); s*_hit only those issued to the memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_csn   <= 1'b1;
      mem_wen   <= 1'b1;
      mem_oen   <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      s1_rd     <= 1'b0;
      s1_hit    <= 1'b0;
      s2_rd     <= 1'b0;
      s2_hit    <= 1'b0;
    end else begin
      mem_csn <= !(accept && in_range);
      mem_wen <= !(accept && in_range && bus.i_we);
      if (accept && in_range) mem_addr <= bus.i_a;
      if (accept && in_range && bus.i_we) mem_wdata <= bus.i_d;
      s1_rd   <= accept && !bus.i_we;
      s1_hit  <= accept && !bus.i_we && in_range;
      s2_rd   <= s1_rd;
      s2_hit  <= s1_hit;
      mem_oen <= !s1_hit;
    end
  end

  assign push   = s2_rd;
  assign pop    = bus.o_v && bus.o_r;
  assign push_d = s2_hit ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      if (push && !pop)      fifo_cnt <= fifo_cnt + CW'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) data_q[wptr] <= push_d;
  end

  assign bus.o_v = (fifo_cnt != '0);
  assign bus.o_d = data_q[rptr];
  assign busy    = s1_rd || s2_rd || bus.o_v;
endmodule
